// File: rtl/nios_fprint_scratchpad_copy_master.sv
// nios_fprint_scratchpad_copy_master
// Avalon-MM master that copies a block of 32-bit words inside the per-core
// scratchpad, one read followed by one write per word, strictly ascending.
// Only one bus transaction is ever outstanding.
//
// Optional feature: define SCRATCHPAD_COPY_CHECKSUM_EN to build a running XOR
// of every word read during a copy. When it is undefined, checksum_o is tied
// to zero and no XOR register exists.
//
// All outputs come straight from registers. The next-state logic computes
// the following-cycle value of every bus output together with the FSM state,
// so the bus pins never glitch and are held while avm_waitrequest_i is high.

module nios_fprint_scratchpad_copy_master #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [ADDR_W:0]     len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W:0]     words_done_o,
    output logic [DATA_W-1:0]   checksum_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    output logic                avm_chipselect_o,
    output logic                avm_write_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    input  logic [DATA_W-1:0]   avm_readdata_i,
    input  logic                avm_waitrequest_i
);

    // Read latency fits in two bits (1..3).
    localparam logic [1:0]        RD_LAT   = READ_LATENCY[1:0];
    localparam logic [1:0]        LAT_ONE  = 2'd1;
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     wd_q, wd_d;
    logic [1:0]          lat_q, lat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ADDR_W:0]     wd_inc_s;
    logic [ADDR_W-1:0]   src_inc_s;
    logic [ADDR_W-1:0]   dst_inc_s;

`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
    logic [DATA_W-1:0]   cks_q, cks_d;

    // Running checksum step: fold one more captured word into the accumulator.
    function automatic logic [DATA_W-1:0] cks_fold(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction
`endif

    // Pointers wrap naturally modulo 2^ADDR_W; the counter is one bit wider
    // so a full 2^ADDR_W-word copy terminates.
    assign wd_inc_s  = wd_q + CNT_ONE;
    assign src_inc_s = src_q + PTR_ONE;
    assign dst_inc_s = dst_q + PTR_ONE;

    // Next-state logic: FSM transitions plus the next value of every registered output.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        wd_d    = wd_q;
        lat_d   = lat_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        cs_d    = cs_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
        cks_d   = cks_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    len_d = len_i;
                    wd_d  = CNT_ZERO;
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
                    cks_d = DAT_ZERO;
`endif
                    if (len_i != CNT_ZERO) begin
                        // First read request goes out the very next cycle.
                        state_d = ST_RD_REQ;
                        addr_d  = src_addr_i;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty copy: finish without touching the bus.
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_REQ: begin
                if (!avm_waitrequest_i) begin
                    // Read accepted this cycle; first latency cycle follows.
                    state_d = ST_RD_WAIT;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    lat_d   = LAT_ONE;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end

            ST_RD_WAIT: begin
                if (lat_q == RD_LAT) begin
                    // Readdata is valid now: capture it and issue the write.
                    rdata_d = avm_readdata_i;
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
                    cks_d   = cks_fold(cks_q, avm_readdata_i);
`endif
                    state_d = ST_WR_REQ;
                    addr_d  = dst_q;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

            ST_WR_REQ: begin
                if (!avm_waitrequest_i) begin
                    wd_d  = wd_inc_s;
                    src_d = src_inc_s;
                    dst_d = dst_inc_s;
                    if (wd_inc_s == len_q) begin
                        state_d = ST_FINISH;
                        cs_d    = 1'b0;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                        addr_d  = src_inc_s;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_WR_REQ;
                end
            end

            ST_FINISH: begin
                // Done is a single-cycle pulse; a start seen here is dropped.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            src_q   <= PTR_ZERO;
            dst_q   <= PTR_ZERO;
            len_q   <= CNT_ZERO;
            wd_q    <= CNT_ZERO;
            lat_q   <= 2'd0;
            rdata_q <= DAT_ZERO;
            addr_q  <= PTR_ZERO;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
    // Checksum accumulator register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cks_q <= DAT_ZERO;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum_o = cks_q;
`else
    assign checksum_o = DAT_ZERO;
`endif

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign words_done_o     = wd_q;
    assign avm_address_o    = addr_q;
    assign avm_byteenable_o = {(DATA_W/8){1'b1}};
    assign avm_chipselect_o = cs_q;
    assign avm_write_o      = we_q;
    assign avm_writedata_o  = rdata_q;

endmodule

// File: tb/tb_nios_fprint_scratchpad_copy_master.sv
// Directed bench for nios_fprint_scratchpad_copy_master (READ_LATENCY = 1).
// A behavioural scratchpad slave lives in the step task: it applies the
// effect of the bus cycle that just ended, 1 ns after each rising edge.
module tb_nios_fprint_scratchpad_copy_master;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] len;
    logic        busy;
    logic        done;
    logic [12:0] words_done;
    logic [31:0] checksum;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    nios_fprint_scratchpad_copy_master #(
        .ADDR_W(12), .DATA_W(32), .READ_LATENCY(1)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .start_i          (start),
        .src_addr_i       (src_addr),
        .dst_addr_i       (dst_addr),
        .len_i            (len),
        .busy_o           (busy),
        .done_o           (done),
        .words_done_o     (words_done),
        .checksum_o       (checksum),
        .avm_address_o    (avm_address),
        .avm_byteenable_o (avm_byteenable),
        .avm_chipselect_o (avm_chipselect),
        .avm_write_o      (avm_write),
        .avm_writedata_o  (avm_writedata),
        .avm_readdata_i   (avm_readdata),
        .avm_waitrequest_i(avm_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:4095];
    logic [11:0] rd_log [0:63];
    logic [11:0] wr_log [0:63];
    int          rd_cnt, wr_cnt, done_cnt, stall_viol, n_cmp, n_err, ncyc;
    logic        busy_seen, cs_seen, bp_en;
    logic        p_cs, p_we, p_wait;
    logic [11:0] p_addr;
    logic [31:0] p_wd;
    logic [31:0] exp_cks;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: slave reacts to the finished cycle, then new waitrequest.
    task automatic step();
        @(posedge clk);
        #1;
        if (p_cs && !p_wait) begin
            if (p_we) begin
                mem[p_addr] = p_wd;
                if (wr_cnt < 64) wr_log[wr_cnt] = p_addr;
                wr_cnt++;
            end else begin
                avm_readdata = mem[p_addr];
                if (rd_cnt < 64) rd_log[rd_cnt] = p_addr;
                rd_cnt++;
            end
        end
        if (p_cs && p_wait) begin
            if (avm_chipselect !== p_cs || avm_write !== p_we ||
                avm_address !== p_addr || avm_writedata !== p_wd)
                stall_viol++;
        end
        avm_waitrequest = bp_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        p_cs   = avm_chipselect;
        p_we   = avm_write;
        p_addr = avm_address;
        p_wd   = avm_writedata;
        p_wait = avm_waitrequest;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (avm_chipselect === 1'b1) cs_seen = 1'b1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; stall_viol = 0;
        busy_seen = 1'b0; cs_seen = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is visible.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ncyc = 0;
        clear_stats();
        bp_en = 1'b0;
        reset_n = 1'b0; start = 1'b0; src_addr = 12'h000; dst_addr = 12'h000; len = 13'd0;
        avm_readdata = 32'h0; avm_waitrequest = 1'b0;
        p_cs = 1'b0; p_we = 1'b0; p_wait = 1'b0; p_addr = 12'h000; p_wd = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | i;

        // Reset values
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_words", words_done, 13'd0);
        check("rst_cks", checksum, 32'h0);
        check("rst_cs", avm_chipselect, 1'b0);
        check("rst_we", avm_write, 1'b0);
        check("rst_addr", avm_address, 12'h000);
        check("rst_wd", avm_writedata, 32'h0);
        check("byteen", avm_byteenable, 4'hF);
        reset_n = 1'b1;
        step();

        // Basic copy: 8 words 0x010 -> 0x100
        for (int i = 0; i < 8; i++) mem[12'h010 + i] = 32'h1000_0000 + i;
        clear_stats();
        do_start(12'h010, 12'h100, 13'd8);
        wait_done(200, ncyc);
        check("basic_cycles", ncyc, 24);
        check("basic_words", words_done, 13'd8);
        check("basic_busy_at_done", busy, 1'b0);
        check("basic_cks", checksum, 32'h0);
        step();
        step();
        check("basic_done_pulse", done, 1'b0);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_words_hold", words_done, 13'd8);
        check("basic_rd_cnt", rd_cnt, 8);
        check("basic_wr_cnt", wr_cnt, 8);
        for (int i = 0; i < 8; i++)
            check("basic_data", mem[12'h100 + i], 32'h1000_0000 + i);

        // Zero length
        clear_stats();
        do_start(12'h020, 12'h030, 13'd0);
        wait_done(10, ncyc);
        check("zero_cycles", ncyc, 0);
        check("zero_words", words_done, 13'd0);
        step();
        check("zero_done_pulse", done, 1'b0);
        check("zero_busy_seen", busy_seen, 1'b0);
        check("zero_cs_seen", cs_seen, 1'b0);
        check("zero_done_cnt", done_cnt, 1);

        // Address wrap
        mem[12'hFFE] = 32'hAAAA_0001; mem[12'hFFF] = 32'hAAAA_0002;
        mem[12'h000] = 32'hAAAA_0003; mem[12'h001] = 32'hAAAA_0004;
        clear_stats();
        do_start(12'hFFE, 12'h7FE, 13'd4);
        wait_done(100, ncyc);
        check("wrap_rd_cnt", rd_cnt, 4);
        check("wrap_rd0", rd_log[0], 12'hFFE);
        check("wrap_rd1", rd_log[1], 12'hFFF);
        check("wrap_rd2", rd_log[2], 12'h000);
        check("wrap_rd3", rd_log[3], 12'h001);
        check("wrap_wr0", wr_log[0], 12'h7FE);
        check("wrap_wr1", wr_log[1], 12'h7FF);
        check("wrap_wr2", wr_log[2], 12'h800);
        check("wrap_wr3", wr_log[3], 12'h801);
        check("wrap_data", mem[12'h800], 32'hAAAA_0003);

        // Backpressure, plus a start pulse while busy that must be ignored
        step();
        clear_stats();
        bp_en = 1'b1;
        do_start(12'h010, 12'h200, 13'd8);
        repeat (5) step();
        src_addr = 12'h000; dst_addr = 12'h000; len = 13'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(600, ncyc);
        bp_en = 1'b0;
        step();
        step();
        check("bp_stall_stable", stall_viol, 0);
        check("bp_rd_cnt", rd_cnt, 8);
        check("bp_wr_cnt", wr_cnt, 8);
        check("bp_words", words_done, 13'd8);
        check("bp_done_cnt", done_cnt, 1);
        for (int i = 0; i < 8; i++)
            check("bp_data", mem[12'h200 + i], 32'h1000_0000 + i);

        // Abort with reset mid-copy, then a clean 2-word copy
        clear_stats();
        do_start(12'h010, 12'h300, 13'd16);
        for (int k = 0; k < 200 && words_done !== 13'd3; k++) step();
        check("abort_reached3", words_done, 13'd3);
        reset_n = 1'b0;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_cs", avm_chipselect, 1'b0);
        check("abort_we", avm_write, 1'b0);
        check("abort_addr", avm_address, 12'h000);
        check("abort_wd", avm_writedata, 32'h0);
        check("abort_words", words_done, 13'd0);
        reset_n = 1'b1;
        step();
        mem[12'h400] = 32'h1234_5678; mem[12'h401] = 32'h9ABC_DEF0;
        clear_stats();
        do_start(12'h400, 12'h500, 13'd2);
        wait_done(50, ncyc);
        check("abort2_cycles", ncyc, 6);
        check("abort2_words", words_done, 13'd2);
        step();
        check("abort2_done_cnt", done_cnt, 1);
        check("abort2_d0", mem[12'h500], 32'h1234_5678);
        check("abort2_d1", mem[12'h501], 32'h9ABC_DEF0);

        // Checksum
        mem[12'h600] = 32'hA5A5_0000; mem[12'h601] = 32'h0000_5A5A; mem[12'h602] = 32'hFFFF_FFFF;
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
        exp_cks = 32'h5A5A_A5A5;
`else
        exp_cks = 32'h0000_0000;
`endif
        clear_stats();
        do_start(12'h600, 12'h610, 13'd3);
        wait_done(50, ncyc);
        check("cks_at_done", checksum, exp_cks);
        step();
        step();
        check("cks_hold", checksum, exp_cks);
        check("cks_data", mem[12'h612], 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
